pattern_sequencer: RTL
======================

Name: pattern_sequencer

Overview:
- Frame-synchronous scheduler that selects which test-pattern generator drives the video RGB path.
- Sits between the video timing counters (hpos/vpos) and the RGB mux in front of the SDL/VGA output.
- Pattern changes happen only at a frame boundary. Each change is followed by a programmable number of black frames.
- Changes are triggered manually by an advance pulse, or automatically after a hold time in frames.

Parameters:
- NUM_PATTERNS, 4, number of selectable patterns; legal range 2..16.
- SEL_W, 4, width of o_sel; must satisfy 2^SEL_W >= NUM_PATTERNS.
- V_RES, 480, first non-visible line; the frame boundary is detected at this line.
- HOLD_FRAMES, 60, frames a pattern is shown before an auto advance; legal range >= 1.
- BLANK_FRAMES, 2, black frames inserted after each switch; legal range >= 1.

Ports:
- i_clk  input  1  pixel clock
- i_reset  input  1  synchronous, active-high reset
- i_hpos  input  10  current horizontal position from the timing generator
- i_vpos  input  10  current vertical position from the timing generator
- i_next  input  1  advance request; single-cycle pulse or level, sampled every cycle
- i_auto_en  input  1  enables automatic advance after HOLD_FRAMES
- o_sel  output  SEL_W  registered pattern index for the RGB mux
- o_blank  output  1  registered; 1 forces black RGB downstream
- o_frame_tick  output  1  registered one-cycle pulse, one cycle after the boundary
- o_frame_count  output  16  free-running frame counter; wraps 0xFFFF -> 0

Behaviour:
- Frame boundary (tick): combinational, tick = (i_hpos == 0) && (i_vpos == V_RES). All frame-based state updates on the clock edge where tick = 1.
- o_frame_tick = tick delayed one cycle. o_frame_count increments on every tick, in any state.
- Reset (synchronous, i_reset = 1 at an edge):
  - state = SHOW, o_sel = 0, o_blank = 0, pending = 0
  - hold_cnt = 0, blank_cnt = 0, o_frame_tick = 0, o_frame_count = 0
  - Reset overrides all other inputs in that cycle, including mid-BLANK and a coincident tick.
- State SHOW (o_blank = 0):
  - i_next = 1 on any cycle sets pending. Multiple requests before the next tick collapse into one advance.
  - At a tick, hold_cnt increments if i_auto_en = 1. If i_auto_en = 0, hold_cnt is held at 0.
  - Auto condition: i_auto_en = 1 and hold_cnt == HOLD_FRAMES-1 at the tick.
  - Advance condition at a tick: (pending | i_next | auto condition). When met:
    - o_sel <= (o_sel == NUM_PATTERNS-1) ? 0 : o_sel + 1
    - state <= BLANK, o_blank <= 1
    - blank_cnt <= 0, pending <= 0, hold_cnt <= 0
  - i_next in the same cycle as the tick counts; the switch occurs at that tick.
- State BLANK (o_blank = 1, o_sel already holds the new index):
  - i_next is ignored and pending stays 0; requests are dropped, not queued.
  - At each tick, blank_cnt increments.
  - When blank_cnt == BLANK_FRAMES-1 at a tick: state <= SHOW, o_blank <= 0, hold_cnt <= 0.
  - A black period therefore lasts exactly BLANK_FRAMES frames, boundary to boundary.
- Latency:
  - o_sel and o_blank change on the clock edge that samples tick, visible in the following cycle together with o_frame_tick.
  - o_sel changes exactly once per advance. o_sel never changes outside a tick edge except on reset.
- i_auto_en toggling mid-frame:
  - Takes effect at the next tick.
  - Deasserting clears hold_cnt on the next cycle, so the hold restarts from 0 when re-enabled.
- Widths:
  - hold_cnt and blank_cnt are sized by $clog2 of their parameter, minimum 1 bit.
  - All counters use compare-to-limit; there is no modular overflow except o_frame_count.

Test Plan:
All cases use a bench timing model with H_TOTAL = 800, V_TOTAL = 525, HOLD_FRAMES = 3, BLANK_FRAMES = 2, NUM_PATTERNS = 4.
- Reset then idle 5 frames with i_auto_en = 0, no i_next -> o_sel = 0, o_blank = 0 throughout; o_frame_tick pulses 5 times, each 1 cycle wide; o_frame_count = 5.
- One i_next pulse at vpos = 100 -> at the next (hpos 0, vpos 480) edge o_sel = 1 and o_blank = 1 in the following cycle; o_blank stays 1 for exactly 2 frames; 3 further i_next pulses during BLANK produce no further change.
- i_auto_en = 1 from reset -> switches occur every 5 frames (3 hold + 2 blank); o_sel sequence 1, 2, 3, 0, 1; wrap 3 -> 0 verified.
- i_next asserted only in the exact tick cycle -> switch at that same tick; i_next held high for a full frame -> only one advance per boundary.
- Assert i_reset during the second BLANK frame with o_sel = 2 -> next cycle o_sel = 0, o_blank = 0, o_frame_count = 0; a tick coincident with reset is ignored.
- Toggle i_auto_en low at hold_cnt = 2, then high again -> no switch at that boundary; the next auto switch occurs 3 frames after re-enable.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern scheduler: picks the pattern index for the RGB mux
// and inserts black frames after every switch, advancing on request or after a hold time.
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 4,
  parameter int SEL_W        = 4,
  parameter int V_RES        = 480,
  parameter int HOLD_FRAMES  = 60,
  parameter int BLANK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_hpos,
  input  logic [9:0]       i_vpos,
  input  logic             i_next,
  input  logic             i_auto_en,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_blank,
  output logic             o_frame_tick,
  output logic [15:0]      o_frame_count
);

  localparam int HOLD_W  = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
  localparam int BLANK_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_FRAMES - 1);
  localparam logic [9:0]         V_BOUNDARY = 10'(V_RES);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               pending_q, pending_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic               tick_q;
  logic [15:0]        frame_count_q, frame_count_d;

  logic tick;
  logic auto_fire;

  assign tick      = (i_hpos == 10'd0) && (i_vpos == V_BOUNDARY);
  assign auto_fire = i_auto_en && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    pending_d     = pending_q;
    hold_cnt_d    = hold_cnt_q;
    blank_cnt_d   = blank_cnt_q;
    frame_count_d = tick ? frame_count_q + 16'd1 : frame_count_q;

    case (state_q)
      SHOW: begin
        // Dropping auto mode restarts the hold from zero on re-enable.
        if (!i_auto_en) hold_cnt_d = '0;
        if (i_next) pending_d = 1'b1;
        if (tick) begin
          if (pending_q || i_next || auto_fire) begin
            sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            state_d     = BLANK;
            blank_cnt_d = '0;
            pending_d   = 1'b0;
            hold_cnt_d  = '0;
          end else if (i_auto_en) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      BLANK: begin
        // Requests arriving while black are dropped rather than queued.
        pending_d = 1'b0;
        if (!i_auto_en) hold_cnt_d = '0;
        if (tick) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d    = SHOW;
            hold_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= SHOW;
      sel_q         <= '0;
      pending_q     <= 1'b0;
      hold_cnt_q    <= '0;
      blank_cnt_q   <= '0;
      tick_q        <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      pending_q     <= pending_d;
      hold_cnt_q    <= hold_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      tick_q        <= tick;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_sel         = sel_q;
  assign o_blank       = (state_q == BLANK);
  assign o_frame_tick  = tick_q;
  assign o_frame_count = frame_count_q;

endmodule
